ifmap_row_buffer: RTL and testbench
===================================

# ifmap_row_buffer

Stream-to-row buffer directly downstream of `convert_top`. Accepts the converted layer-3 ifmap AXI-Stream (one row = 208 pixels × 64 ch = 1664 words of 64 bits) and stores complete rows in a circular set of row slots. The conv engine reads any buffered row by slot offset and word index, then releases the oldest row. Backpressure to the convertor is applied when all slots are occupied.

## Interface
- `TBITS`, 64, stream data width
- `TBYTE`, 8, TKEEP width (TBITS/8)
- `ROW_WORDS`, 1664, words per row
- `ROW_SLOTS`, 4, number of row slots (power of two, ≥2)
- `aclk`  in  1  clock, single clock domain
- `areset`  in  1  reset, synchronous, active-high
- `S_AXIS_TVALID`  in  1  input word valid
- `S_AXIS_TREADY`  out  1  buffer can accept a word
- `S_AXIS_TDATA`  in  TBITS  input word
- `S_AXIS_TKEEP`  in  TBYTE  byte enables
- `S_AXIS_TLAST`  in  1  last word of row
- `rd_en`  in  1  read request
- `rd_row`  in  clog2(ROW_SLOTS)  row offset from oldest committed row
- `rd_word`  in  clog2(ROW_WORDS)  word index within row
- `rd_data`  out  TBITS  read data
- `rd_valid`  out  1  rd_data valid
- `row_release`  in  1  free oldest committed row (1-cycle pulse)
- `rows_avail`  out  clog2(ROW_SLOTS)+1  committed rows held
- `err_len`  out  1  sticky row-length error
- `err_keep`  out  1  sticky TKEEP error (see Configuration)

## Operation
- Write side: counters `wr_word` (0..ROW_WORDS-1) and `wr_slot` (mod ROW_SLOTS). Transfer on TVALID&TREADY writes TDATA to slot `wr_slot`, address `wr_word`.
- Commit: row committed when `wr_word==ROW_WORDS-1` or TLAST accepted, whichever first; then `wr_word`←0, `wr_slot`←`wr_slot+1`, `rows_avail`+1.
- TLAST on word < ROW_WORDS-1: early commit, remaining words of that slot undefined, `err_len`←1. Word ROW_WORDS-1 without TLAST: commit, `err_len`←1; next words start a new row.
- TREADY = `rows_avail < ROW_SLOTS` (slot being filled is never committed-occupied). Combinational from registered count only; never from TVALID.
- Read side: physical slot = `rd_slot_base + rd_row` (mod ROW_SLOTS). `rd_row ≥ rows_avail` is illegal: `rd_valid` still asserts, data undefined.
- `row_release` with `rows_avail==0` ignored. Otherwise `rd_slot_base`+1, `rows_avail`−1.
- Commit and release in same cycle: `rows_avail` unchanged, both pointers advance.
- Reset values: `S_AXIS_TREADY`=1 one cycle after reset deassertion (0 during reset), `rd_data`=0, `rd_valid`=0, `rows_avail`=0, `err_len`=0, `err_keep`=0; all pointers/counters 0. Reset mid-row discards the partial row and all committed rows.

## Timing
- Read latency 1 cycle: `rd_en` at cycle N → `rd_data`/`rd_valid` at N+1; `rd_valid` is a registered copy of `rd_en`.
- Write-then-read of same word in same cycle not possible (row not yet committed).
- `rows_avail` updates the cycle after the committing transfer; TREADY falls that same cycle when count reaches ROW_SLOTS.
- Throughput: one word per cycle on both sides, concurrently.

## Configuration
- `ROWBUF_TKEEP_CHECK_EN` defined: any accepted word with TKEEP ≠ all-ones sets `err_keep` (sticky until reset); data still written.
- Undefined: TKEEP ignored, `err_keep` tied 0.

## Structure
- Package `rowbuf_pkg`: default ROW_WORDS/ROW_SLOTS constants, derived widths (`WORD_AW`, `SLOT_AW`), typedef for the `{slot, word}` RAM address.
- One sub-module `rowbuf_ram`: simple dual-port RAM, depth ROW_SLOTS×ROW_WORDS, one write port, one registered read port; address = slot×ROW_WORDS + word.

## Test plan
- Reset then stream one row of 1664 words `data=i`, TLAST on word 1663 → `rows_avail`=1, read `rd_row=0, rd_word=1000` returns 1000 one cycle later, no errors.
- Stream 5 rows, no release → TREADY low after 4th commit, 5th row stalls at word 0; one `row_release` → TREADY high next cycle, 5th row completes, `rows_avail`=4.
- TLAST on word 99 → row committed, `err_len`=1, next row starts at slot 1 word 0.
- Commit and `row_release` in same cycle with `rows_avail`=2 → stays 2; `rd_row=0` now reads the former second row.
- Assert `areset` at word 800 of row 2 → `rows_avail`=0, errors cleared, next stream fills slot 0 from word 0.
- With `ROWBUF_TKEEP_CHECK_EN`, one word TKEEP=8'h0f → `err_keep`=1; without macro → `err_keep`=0.

Source files
------------

// File: rtl/rowbuf_pkg.sv
// Shared constants and types for the ifmap row buffer.
package rowbuf_pkg;

  localparam int unsigned ROW_WORDS_DEF = 1664;
  localparam int unsigned ROW_SLOTS_DEF = 4;
  localparam int unsigned WORD_AW       = $clog2(ROW_WORDS_DEF);
  localparam int unsigned SLOT_AW       = $clog2(ROW_SLOTS_DEF);

  // Row-structured RAM address at the default geometry.
  typedef struct packed {
    logic [SLOT_AW-1:0] slot;
    logic [WORD_AW-1:0] word;
  } ram_addr_t;

  // Flat RAM index of a (slot, word) pair; rows are laid out back to back.
  function automatic int unsigned ram_index(input int unsigned slot,
                                            input int unsigned word,
                                            input int unsigned row_words);
    return slot * row_words + word;
  endfunction

endpackage

// File: rtl/rowbuf_ram.sv
// Simple dual-port row RAM: one write port, one registered read port.
module rowbuf_ram
  import rowbuf_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned SLOTS = ROW_SLOTS_DEF,
  parameter int unsigned WORDS = ROW_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(SLOTS)-1:0] wr_slot,
  input  logic [$clog2(WORDS)-1:0] wr_word,
  input  logic [DW-1:0]            wr_data,
  input  logic                     re,
  input  logic [$clog2(SLOTS)-1:0] rd_slot,
  input  logic [$clog2(WORDS)-1:0] rd_word,
  output logic [DW-1:0]            rd_data
);

  localparam int unsigned DEPTH = SLOTS * WORDS;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr = AW'(ram_index(32'(wr_slot), 32'(wr_word), WORDS));
  assign rd_addr = AW'(ram_index(32'(rd_slot), 32'(rd_word), WORDS));

  // Write port; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ifmap_row_buffer.sv
// Stream-to-row buffer: collects AXI-Stream rows into a ring of row slots
// and serves random word reads from committed rows.
// Optional macro ROWBUF_TKEEP_CHECK_EN enables the sticky err_keep check.
module ifmap_row_buffer
  import rowbuf_pkg::*;
#(
  parameter int unsigned TBITS     = 64,
  parameter int unsigned TBYTE     = TBITS / 8,
  parameter int unsigned ROW_WORDS = ROW_WORDS_DEF,
  parameter int unsigned ROW_SLOTS = ROW_SLOTS_DEF
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [TBITS-1:0]             S_AXIS_TDATA,
  input  logic [TBYTE-1:0]             S_AXIS_TKEEP,
  input  logic                         S_AXIS_TLAST,
  input  logic                         rd_en,
  input  logic [$clog2(ROW_SLOTS)-1:0] rd_row,
  input  logic [$clog2(ROW_WORDS)-1:0] rd_word,
  output logic [TBITS-1:0]             rd_data,
  output logic                         rd_valid,
  input  logic                         row_release,
  output logic [$clog2(ROW_SLOTS):0]   rows_avail,
  output logic                         err_len,
  output logic                         err_keep
);

  localparam int unsigned SLOT_W = $clog2(ROW_SLOTS);
  localparam int unsigned WORD_W = $clog2(ROW_WORDS);
  localparam int unsigned CNT_W  = SLOT_W + 1;

  logic [WORD_W-1:0] wr_word;
  logic [SLOT_W-1:0] wr_slot;
  logic [SLOT_W-1:0] rd_slot_base;
  logic [SLOT_W-1:0] rd_slot;
  logic              ready_en;
  logic              xfer;
  logic              last_word;
  logic              commit;
  logic              release_ok;

  // Ready only from registered state: out of reset and a free slot exists.
  assign S_AXIS_TREADY = ready_en && (rows_avail < CNT_W'(ROW_SLOTS));
  assign xfer          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_word     = (wr_word == WORD_W'(ROW_WORDS - 1));
  assign commit        = xfer && (S_AXIS_TLAST || last_word);
  assign release_ok    = row_release && (rows_avail != '0);
  assign rd_slot       = rd_slot_base + rd_row;

  // Write pointer: word index within row, slot advances on commit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_word <= '0;
      wr_slot <= '0;
    end else if (commit) begin
      wr_word <= '0;
      wr_slot <= wr_slot + SLOT_W'(1);
    end else if (xfer) begin
      wr_word <= wr_word + WORD_W'(1);
    end
  end

  // Committed-row count and oldest-row pointer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rows_avail   <= '0;
      rd_slot_base <= '0;
    end else begin
      if (release_ok) rd_slot_base <= rd_slot_base + SLOT_W'(1);
      case ({commit, release_ok})
        2'b10:   rows_avail <= rows_avail + CNT_W'(1);
        2'b01:   rows_avail <= rows_avail - CNT_W'(1);
        default: rows_avail <= rows_avail;
      endcase
    end
  end

  // Ready enable, read-valid pipe and sticky length error.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ready_en <= 1'b0;
      rd_valid <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rd_valid <= rd_en;
      if (xfer && (S_AXIS_TLAST != last_word)) err_len <= 1'b1;
    end
  end

`ifdef ROWBUF_TKEEP_CHECK_EN
  // Sticky flag for any accepted word with partial byte enables.
  always_ff @(posedge aclk) begin
    if (areset)                                   err_keep <= 1'b0;
    else if (xfer && (S_AXIS_TKEEP != '1))        err_keep <= 1'b1;
  end
`else
  logic unused_keep;
  assign unused_keep = ^S_AXIS_TKEEP;
  assign err_keep    = 1'b0;
`endif

  rowbuf_ram #(
    .DW    (TBITS),
    .SLOTS (ROW_SLOTS),
    .WORDS (ROW_WORDS)
  ) u_ram (
    .clk     (aclk),
    .rst     (areset),
    .we      (xfer),
    .wr_slot (wr_slot),
    .wr_word (wr_word),
    .wr_data (S_AXIS_TDATA),
    .re      (rd_en),
    .rd_slot (rd_slot),
    .rd_word (rd_word),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ifmap_row_buffer.sv
// Self-checking bench for ifmap_row_buffer against a queue-of-rows model.
module tb_ifmap_row_buffer;

  localparam int unsigned W  = 1664;
  localparam int unsigned S  = 4;
  localparam int unsigned SW = $clog2(S);
  localparam int unsigned WW = $clog2(W);
`ifdef ROWBUF_TKEEP_CHECK_EN
  localparam bit KEEP_EN = 1'b1;
`else
  localparam bit KEEP_EN = 1'b0;
`endif

  logic          aclk;
  logic          areset;
  logic          tvalid;
  logic          tready;
  logic [63:0]   tdata;
  logic [7:0]    tkeep;
  logic          tlast;
  logic          rd_en;
  logic [SW-1:0] rd_row;
  logic [WW-1:0] rd_word;
  logic [63:0]   rd_data;
  logic          rd_valid;
  logic          row_release;
  logic [SW:0]   rows_avail;
  logic          err_len;
  logic          err_keep;

  ifmap_row_buffer #(
    .TBITS(64), .TBYTE(8), .ROW_WORDS(W), .ROW_SLOTS(S)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TKEEP  (tkeep),
    .S_AXIS_TLAST  (tlast),
    .rd_en         (rd_en),
    .rd_row        (rd_row),
    .rd_word       (rd_word),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .row_release   (row_release),
    .rows_avail    (rows_avail),
    .err_len       (err_len),
    .err_keep      (err_keep)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Model: committed rows oldest first; each row's word w holds {tag, w}.
  typedef struct {
    int unsigned tag;
    int unsigned len;
  } row_t;

  row_t q[$];
  bit   exp_err_len;
  bit   exp_err_keep;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic chk_status(input string name);
    chk({name, ".rows_avail"}, 64'(rows_avail), 64'(q.size()));
    chk({name, ".tready"},     64'(tready),     64'(q.size() < S));
    chk({name, ".err_len"},    64'(err_len),    64'(exp_err_len));
    chk({name, ".err_keep"},   64'(err_keep),   64'(exp_err_keep));
  endtask

  // Read one word of a committed row; called and returns at a negedge.
  task automatic chk_read(input int unsigned row, input int unsigned word);
    logic [63:0] expv;
    expv    = {q[row].tag[31:0], word[31:0]};
    rd_en   = 1'b1;
    rd_row  = SW'(row);
    rd_word = WW'(word);
    @(negedge aclk);
    rd_en = 1'b0;
    chk($sformatf("rd_valid[%0d,%0d]", row, word), 64'(rd_valid), 64'd1);
    chk($sformatf("rd_data[%0d,%0d]", row, word), rd_data, expv);
  endtask

  task automatic release_row();
    row_release = 1'b1;
    @(negedge aclk);
    row_release = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  // Stream words first..len-1 of a row; optional TLAST on last word,
  // release pulse on last word, one word with TKEEP=8'h0f, random idles.
  task automatic send_row(input int unsigned tag, input int first, input int len,
                          input bit last, input bit rel, input int keep_bad,
                          input int gap);
    int stall;
    bit committed;
    for (int w = first; w < len; w++) begin
      while (int'($urandom_range(99)) < gap) begin
        tvalid = 1'b0;
        @(negedge aclk);
      end
      tvalid      = 1'b1;
      tdata       = {tag[31:0], 32'(w)};
      tkeep       = (w == keep_bad) ? 8'h0f : 8'hff;
      tlast       = last && (w == len - 1);
      row_release = rel && (w == len - 1);
      stall = 0;
      while (!tready && stall < 100) begin
        @(negedge aclk);
        stall++;
      end
      if (!tready) begin
        chk("tready_timeout", 64'(tready), 64'd1);
        tvalid = 1'b0; tlast = 1'b0; row_release = 1'b0;
        return;
      end
      @(negedge aclk);
      if (w == keep_bad && KEEP_EN) exp_err_keep = 1'b1;
    end
    tvalid = 1'b0; tlast = 1'b0; row_release = 1'b0; tkeep = 8'hff;
    committed = last || (len == int'(W));
    if (committed) begin
      if (last != (len == int'(W))) exp_err_len = 1'b1;
      if (rel && q.size() > 0) void'(q.pop_front());
      q.push_back('{tag: tag, len: len});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tag5;
    areset = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = 8'hff; tlast = 1'b0;
    rd_en = 1'b0; rd_row = '0; rd_word = '0; row_release = 1'b0;
    exp_err_len = 1'b0; exp_err_keep = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("reset.tready", 64'(tready), 64'd0);
    chk("reset.rows_avail", 64'(rows_avail), 64'd0);
    chk("reset.rd_valid", 64'(rd_valid), 64'd0);
    chk("reset.rd_data", rd_data, 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk_status("after_reset");

    // One full row with data = word index
    send_row(0, 0, W, 1, 0, -1, 0);
    chk_status("row1");
    chk_read(0, 1000);
    chk("row1.data_literal", rd_data, 64'd1000);

    // Fill all slots, then stall the fifth row at word 0
    for (int r = 0; r < 3; r++) send_row($urandom, 0, W, 1, 0, -1, 20);
    chk_status("four_rows");
    for (int k = 0; k < 4; k++) chk_read($urandom_range(3), $urandom_range(W - 1));
    tag5   = $urandom;
    tvalid = 1'b1; tdata = {tag5, 32'd0}; tlast = 1'b0;
    repeat (5) @(negedge aclk);
    chk("stall.tready", 64'(tready), 64'd0);
    chk("stall.rows_avail", 64'(rows_avail), 64'd4);
    release_row();
    chk("released.tready", 64'(tready), 64'd1);
    @(negedge aclk);
    send_row(tag5, 1, W, 1, 0, -1, 10);
    chk_status("fifth_row");
    chk_read(3, 0);
    chk_read(3, W - 1);
    chk_read(0, $urandom_range(W - 1));

    // Early TLAST on word 99
    for (int r = 0; r < 3; r++) release_row();
    chk_status("drained_to_one");
    send_row($urandom, 0, 100, 1, 0, -1, 0);
    chk_status("short_row");
    chk_read(1, 0);
    chk_read(1, 99);

    // Commit and release in the same cycle
    send_row($urandom, 0, W, 1, 1, -1, 0);
    chk_status("commit_release");
    chk_read(0, 50);
    chk_read(1, $urandom_range(W - 1));

    // Reset in the middle of a row
    send_row($urandom, 0, W, 1, 0, -1, 0);
    send_row($urandom, 0, 800, 0, 0, -1, 0);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_reset.tready", 64'(tready), 64'd0);
    chk("mid_reset.rows_avail", 64'(rows_avail), 64'd0);
    chk("mid_reset.err_len", 64'(err_len), 64'd0);
    areset = 1'b0;
    q.delete();
    exp_err_len = 1'b0; exp_err_keep = 1'b0;
    @(negedge aclk);
    chk_status("after_mid_reset");
    release_row();
    chk_status("release_empty");

    // New stream fills from word 0; one word with partial TKEEP
    send_row($urandom, 0, W, 1, 0, 5, 0);
    chk_status("keep_row");
    chk_read(0, 0);
    chk_read(0, 5);
    chk_read(0, W - 1);

    // Full-length row without TLAST, then a normal row
    send_row($urandom, 0, W, 0, 0, -1, 0);
    chk_status("no_tlast_row");
    send_row($urandom, 0, W, 1, 0, -1, 5);
    chk_status("after_no_tlast");
    chk_read(1, W - 1);
    chk_read(2, 0);
    chk_read(2, $urandom_range(W - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
